// File: rtl/fifo_deq_streamer.sv
// fifo_deq_streamer: drains a first-word-fall-through FIFO into a registered two-entry
// ready/valid stream, counting beats and flagging the last beat of each fixed-length burst.
module fifo_deq_streamer #(
   parameter int WIDTH     = 32,
   parameter int BURST_LEN = 16,
   parameter int CNT_WIDTH = 5
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 CLR,
   input  logic [WIDTH-1:0]     FIFO_D_OUT,
   input  logic                 FIFO_EMPTY_N,
   output logic                 FIFO_DEQ,
   output logic [WIDTH-1:0]     M_DATA,
   output logic                 M_VALID,
   output logic                 M_LAST,
   input  logic                 M_READY,
   output logic [CNT_WIDTH-1:0] BEAT_CNT
);
   localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(BURST_LEN - 1);
   logic [1:0]           r_cnt;
   logic [WIDTH-1:0]     r_head;
   logic [WIDTH-1:0]     r_skid;
   logic [CNT_WIDTH-1:0] r_beat;
   logic                 w_flush;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_last;
   // Dequeue looks only at registered occupancy, so M_READY never reaches FIFO_DEQ.
   assign w_flush  = RST | CLR;
   assign FIFO_DEQ = FIFO_EMPTY_N & ~r_cnt[1] & ~w_flush;
   assign w_push   = FIFO_DEQ;
   assign M_VALID  = r_cnt != 2'd0;
   assign w_pop    = M_VALID & M_READY;
   assign w_last   = r_beat == LAST_IDX;
   assign M_LAST   = M_VALID & w_last;
   assign M_DATA   = r_head;
   assign BEAT_CNT = r_beat;
   always_ff @(posedge CLK) begin
      if (w_flush) begin
         r_cnt  <= 2'd0;
         r_head <= '0;
         r_skid <= '0;
         r_beat <= '0;
      end else begin
         r_cnt <= (w_push & ~w_pop) ? r_cnt + 2'd1 : (w_pop & ~w_push) ? r_cnt - 2'd1 : r_cnt;
         if (w_pop & r_cnt[1])
            r_head <= r_skid;
         else if (w_push & (r_cnt == 2'd0 | w_pop))
            r_head <= FIFO_D_OUT;
         if (w_push & r_cnt == 2'd1 & ~w_pop)
            r_skid <= FIFO_D_OUT;
         if (w_pop)
            r_beat <= w_last ? '0 : r_beat + 1'b1;
      end
   end
endmodule

// File: tb/tb_fifo_deq_streamer.sv
// tb_fifo_deq_streamer: queue-based FIFO and in-flight model with a negedge scoreboard monitor,
// plus a BURST_LEN=1 instance exercised with a short directed sequence.
module tb_fifo_deq_streamer;
   localparam int BL = 16;
   logic        CLK, RST, CLR, FIFO_EMPTY_N, FIFO_DEQ, M_VALID, M_LAST, M_READY;
   logic [31:0] FIFO_D_OUT, M_DATA;
   logic [4:0]  BEAT_CNT;
   logic        b_rst, b_empty_n, b_deq, b_valid, b_last, b_ready;
   logic [31:0] b_dout, b_data;
   logic [4:0]  b_beat;
   int          checks = 0, failures = 0;
   int          beats = 0, popped = 0, deq_total = 0;
   bit          started = 0, rst_prev = 0, gate = 0;
   logic [31:0] fifo_q[$];
   logic [31:0] buf_q[$];

   fifo_deq_streamer #(.WIDTH(32), .BURST_LEN(BL), .CNT_WIDTH(5)) dut (
      .CLK(CLK), .RST(RST), .CLR(CLR), .FIFO_D_OUT(FIFO_D_OUT), .FIFO_EMPTY_N(FIFO_EMPTY_N),
      .FIFO_DEQ(FIFO_DEQ), .M_DATA(M_DATA), .M_VALID(M_VALID), .M_LAST(M_LAST),
      .M_READY(M_READY), .BEAT_CNT(BEAT_CNT));

   fifo_deq_streamer #(.WIDTH(32), .BURST_LEN(1), .CNT_WIDTH(5)) dut1 (
      .CLK(CLK), .RST(b_rst), .CLR(1'b0), .FIFO_D_OUT(b_dout), .FIFO_EMPTY_N(b_empty_n),
      .FIFO_DEQ(b_deq), .M_DATA(b_data), .M_VALID(b_valid), .M_LAST(b_last),
      .M_READY(b_ready), .BEAT_CNT(b_beat));

   initial begin
      CLK = 0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic do_reset();
      RST = 1;
      fifo_q.delete();
      step(2);
      RST = 0;
   endtask

   // FIFO head and non-empty flag follow the model queue shortly after each edge.
   always @(posedge CLK) begin
      #3;
      FIFO_EMPTY_N = gate && fifo_q.size() != 0;
      FIFO_D_OUT   = fifo_q.size() != 0 ? fifo_q[0] : 32'h0;
   end

   always @(negedge CLK) begin
      if (started) begin
         chk("deq", {63'h0, FIFO_DEQ}, {63'h0, FIFO_EMPTY_N && buf_q.size() < 2 && !RST && !CLR});
         chk("valid", {63'h0, M_VALID}, {63'h0, buf_q.size() != 0});
         chk("beat", {59'h0, BEAT_CNT}, 64'(beats % BL));
         chk("last", {63'h0, M_LAST}, {63'h0, buf_q.size() != 0 && beats % BL == BL - 1});
         if (buf_q.size() != 0) chk("data", {32'h0, M_DATA}, {32'h0, buf_q[0]});
         if (rst_prev) chk("rst_data", {32'h0, M_DATA}, 64'h0);
      end
      rst_prev = RST;
      if (RST || CLR) begin
         buf_q.delete();
         beats = 0;
         if (RST) started = 1;
      end else begin
         if (buf_q.size() != 0 && M_READY) begin
            void'(buf_q.pop_front());
            beats++;
            popped++;
         end
         if (FIFO_DEQ && fifo_q.size() != 0) begin
            buf_q.push_back(fifo_q.pop_front());
            deq_total++;
         end
      end
   end

   initial begin
      int p0, d0, pushed;
      logic [31:0] first, bq[$], bexp[$];
      RST = 1; CLR = 0; M_READY = 0; FIFO_EMPTY_N = 0; FIFO_D_OUT = 0;
      b_rst = 1; b_empty_n = 0; b_dout = 0; b_ready = 0;
      do_reset();
      chk("reset_valid", {63'h0, M_VALID}, 64'h0);
      chk("reset_beat", {59'h0, BEAT_CNT}, 64'h0);
      // three-word transfer
      gate = 1; M_READY = 1;
      fifo_q.push_back(32'h11); fifo_q.push_back(32'h22); fifo_q.push_back(32'h33);
      p0 = popped;
      step(5);
      chk("three_words", 64'(popped - p0), 64'd3);
      // 40-word continuous stream
      do_reset();
      for (int i = 0; i < 40; i++) fifo_q.push_back($urandom);
      p0 = popped;
      step(41);
      chk("stream40_beats", 64'(popped - p0), 64'd40);
      chk("stream40_beatcnt", {59'h0, BEAT_CNT}, 64'd8);
      // backpressure
      do_reset();
      M_READY = 0;
      for (int i = 0; i < 5; i++) fifo_q.push_back($urandom);
      first = fifo_q[0];
      d0 = deq_total; p0 = popped;
      step(6);
      chk("stall_deqs", 64'(deq_total - d0), 64'd2);
      chk("stall_head", {32'h0, M_DATA}, {32'h0, first});
      M_READY = 1;
      step(7);
      chk("stall_release", 64'(popped - p0), 64'd5);
      // flush mid-burst with a full buffer
      do_reset();
      for (int i = 0; i < 40; i++) fifo_q.push_back($urandom);
      for (int i = 0; i < 30 && beats != 7; i++) step();
      chk("reach_beat7", 64'(beats), 64'd7);
      M_READY = 0;
      step();
      chk("clr_full", 64'(buf_q.size()), 64'd2);
      CLR = 1;
      step();
      CLR = 0;
      chk("clr_valid", {63'h0, M_VALID}, 64'h0);
      chk("clr_beat", {59'h0, BEAT_CNT}, 64'h0);
      M_READY = 1;
      step(25);
      // randomized traffic
      pushed = 0;
      for (int c = 0; c < 60000 && pushed < 10000; c++) begin
         if ($urandom_range(1, 0) == 1 && fifo_q.size() < 8) begin
            fifo_q.push_back($urandom);
            pushed++;
         end
         gate = $urandom_range(3, 0) != 0;
         M_READY = $urandom_range(1, 0) == 1;
         CLR = $urandom_range(999, 0) == 0;
         step();
      end
      chk("random_pushed", 64'(pushed), 64'd10000);
      CLR = 0; gate = 1; M_READY = 1;
      for (int c = 0; c < 200 && (fifo_q.size() != 0 || buf_q.size() != 0); c++) step();
      chk("drained", 64'(fifo_q.size() + buf_q.size()), 64'd0);
      // BURST_LEN=1 instance
      step();
      b_rst = 0; b_ready = 1;
      for (int i = 0; i < 4; i++) begin
         bq.push_back($urandom);
         bexp.push_back(bq[i]);
      end
      p0 = 0;
      for (int c = 0; c < 20 && p0 < 4; c++) begin
         b_empty_n = bq.size() != 0;
         b_dout = bq.size() != 0 ? bq[0] : 32'h0;
         @(negedge CLK);
         if (b_valid) begin
            chk("b1_data", {32'h0, b_data}, {32'h0, bexp[p0]});
            chk("b1_last", {63'h0, b_last}, 64'h1);
            chk("b1_beat", {59'h0, b_beat}, 64'h0);
         end
         if (b_deq && bq.size() != 0) void'(bq.pop_front());
         if (b_valid && b_ready) p0++;
         step();
      end
      chk("b1_beats", 64'(p0), 64'd4);
      b_ready = 0;
      bq.push_back($urandom);
      for (int c = 0; c < 5 && !b_valid; c++) begin
         b_empty_n = bq.size() != 0;
         b_dout = bq.size() != 0 ? bq[0] : 32'h0;
         @(negedge CLK);
         if (b_deq && bq.size() != 0) void'(bq.pop_front());
         step();
      end
      b_empty_n = 0;
      chk("b1_valid_pre", {63'h0, b_valid}, 64'h1);
      b_rst = 1;
      step();
      b_rst = 0;
      chk("b1_rst_valid", {63'h0, b_valid}, 64'h0);
      chk("b1_rst_data", {32'h0, b_data}, 64'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
